// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: address width, instruction size, reset vector
// and the next-PC source encoding.
package mips_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Next-PC source, listed from lowest to highest priority
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_LOAD   = 2'd3
  } pc_src_t;

endpackage

// File: rtl/program_counter_if.sv
// Control/address bundle between fetch control (master) and the program counter (slave).
interface program_counter_if #(
  parameter int unsigned WIDTH = mips_pkg::ADDR_W
);

  logic             PCWrite;
  logic [WIDTH-1:0] PCWriteValue;
  logic             load;
  logic             jump;
  logic [WIDTH-1:0] jumpAddress;
  logic             branch;
  logic [WIDTH-1:0] branchAddress;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;

  modport master (
    output PCWrite, PCWriteValue, load, jump, jumpAddress, branch, branchAddress,
    input  pc, pc_plus4
  );

  modport slave (
    input  PCWrite, PCWriteValue, load, jump, jumpAddress, branch, branchAddress,
    output pc, pc_plus4
  );

endinterface

// File: rtl/pc_adder.sv
// Combinational modulo-2^WIDTH adder; used for PC+4 and for branch-target arithmetic.
module pc_adder #(
  parameter int unsigned WIDTH = mips_pkg::ADDR_W
) (
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] sum
);

  // Carry out is intentionally discarded: wraps modulo 2^WIDTH
  assign sum = operandA + operandB;

endmodule

// File: rtl/program_counter.sv
// Fetch program counter: priority next-address select (load > jump > branch > PC+4),
// word-alignment masking, and the stallable pc register.
module program_counter #(
  parameter int unsigned     WIDTH        = mips_pkg::ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(mips_pkg::RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  program_counter_if.slave bus
);

  import mips_pkg::*;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] RESET_PC   = RESET_VECTOR & ALIGN_MASK;

  pc_src_t          src_c;
  logic [WIDTH-1:0] next_c;
  logic [WIDTH-1:0] pc_plus4_c;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  pc_adder #(.WIDTH(WIDTH)) u_pc_adder (
    .operandA (pc_q),
    .operandB (WIDTH'(INSTR_BYTES)),
    .sum      (pc_plus4_c)
  );

  // Fixed-priority source select
  always_comb begin
    src_c = PC_SEQ;
    if (bus.load) begin
      src_c = PC_LOAD;
    end else if (bus.jump) begin
      src_c = PC_JUMP;
    end else if (bus.branch) begin
      src_c = PC_BRANCH;
    end
  end

  always_comb begin
    next_c = pc_plus4_c;
    case (src_c)
      PC_LOAD:   next_c = bus.PCWriteValue;
      PC_JUMP:   next_c = bus.jumpAddress;
      PC_BRANCH: next_c = bus.branchAddress;
      default:   next_c = pc_plus4_c;
    endcase
    // Stall overrides every source, including load
    pc_d = bus.PCWrite ? (next_c & ALIGN_MASK) : pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4_c;

endmodule

// File: tb/tb_program_counter.sv
// Directed + randomized bench for program_counter against a behavioural next-PC model.
module tb_program_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  program_counter_if bus ();

  program_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, advance one edge, compare pc and pc_plus4
  task automatic cycle(input string tag, input bit pw, input bit ld, input bit jp, input bit br,
                       input logic [31:0] wv, input logic [31:0] ja, input logic [31:0] ba);
    logic [31:0] nxt;
    bus.PCWrite       = pw;
    bus.load          = ld;
    bus.jump          = jp;
    bus.branch        = br;
    bus.PCWriteValue  = wv;
    bus.jumpAddress   = ja;
    bus.branchAddress = ba;
    if (pw) begin
      if (ld)      nxt = wv;
      else if (jp) nxt = ja;
      else if (br) nxt = ba;
      else         nxt = exp_pc + 32'd4;
      exp_pc = {nxt[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, bus.pc, exp_pc);
    chk({tag, "_pc_plus4"}, bus.pc_plus4, exp_pc + 32'd4);
  endtask

  initial begin
    rst               = 1'b0;
    bus.PCWrite       = 1'b1;
    bus.load          = 1'b0;
    bus.jump          = 1'b0;
    bus.branch        = 1'b0;
    bus.PCWriteValue  = '0;
    bus.jumpAddress   = '0;
    bus.branchAddress = '0;
    exp_pc            = 32'h0;

    #3;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_pc_plus4", bus.pc_plus4, 32'h4);
    #4;
    rst = 1'b1;

    // Free run, then branch at pc=8
    cycle("seq", 1, 0, 0, 0, 0, 0, 0);
    cycle("seq", 1, 0, 0, 0, 0, 0, 0);
    chk("at_8", bus.pc, 32'h8);
    cycle("branch", 1, 0, 0, 1, 0, 0, 32'h40);
    chk("branch_tgt", bus.pc, 32'h40);
    cycle("after_branch", 1, 0, 0, 0, 0, 0, 0);
    chk("branch_seq", bus.pc, 32'h44);

    // Priority
    cycle("prio_load", 1, 1, 1, 1, 32'h8000_0180, 32'h100, 32'h40);
    chk("prio_load_val", bus.pc, 32'h8000_0180);
    cycle("prio_jump", 1, 0, 1, 1, 32'h8000_0180, 32'h100, 32'h40);
    chk("prio_jump_val", bus.pc, 32'h100);

    // Stall with jump asserted, then misaligned jump
    for (int i = 0; i < 3; i++) cycle("stall", 0, 1, 1, 1, 32'h0, 32'h300, 32'h40);
    chk("stall_hold", bus.pc, 32'h100);
    cycle("align", 1, 0, 1, 0, 0, 32'h203, 0);
    chk("align_val", bus.pc, 32'h200);

    // Wrap
    cycle("load_top", 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 0);
    chk("top_plus4_wrap", bus.pc_plus4, 32'h0);
    cycle("wrap", 1, 0, 0, 0, 0, 0, 0);
    chk("wrap_val", bus.pc, 32'h0);
    for (int i = 0; i < 9; i++) cycle("run", 1, 0, 0, 0, 0, 0, 0);
    chk("at_24", bus.pc, 32'h24);

    // Async reset mid-cycle; pending jump discarded
    rst = 1'b0;
    bus.jump        = 1'b1;
    bus.jumpAddress = 32'h300;
    #2;
    chk("async_rst_pc", bus.pc, 32'h0);
    chk("async_rst_plus4", bus.pc_plus4, 32'h4);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", bus.pc, 32'h0);
    #2;
    rst    = 1'b1;
    exp_pc = 32'h0;
    cycle("post_rst", 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_val", bus.pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 4) == 0),
            $urandom, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
